// File: rtl/uart_rx_framed_if.sv
// Receive-side handshake bundle for uart_rx_framed: word, error flags and valid/ready.
interface uart_rx_framed_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;

  modport master (
    output data,
    output valid,
    output parity_err,
    output frame_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample majority vote, optional parity,
// 1/2 stop bits, and a valid/ready output carrying parity/framing/overrun status.
module uart_rx_framed #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CLKDIV    = 16,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  uart_rx_framed_if.master     bus
);

  localparam int unsigned CW = $clog2(CLKDIV);
  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam int unsigned H  = CLKDIV / 2;

  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD  = 1'(PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       sync;
  logic             rx_s;
  logic             rx_prev;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic             stop_idx;
  logic [1:0]       smp;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;
  logic             ferr_pend;

  logic fall_c, vote_c, decide_c, bit_end_c, last_bit_c, stop_last_c;
  logic cnt_clr_c, frame_clr_c, shift_c, idx_inc_c, par_cap_c, stop_cap_c, stop_inc_c;
  logic commit_c, parity_err_c, frame_err_c, handshake_c;

  // Synchroniser presets to idle-high so leaving reset cannot fake a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  assign rx_s        = sync[1];
  assign fall_c      = rx_prev & ~rx_s;
  assign decide_c    = (cnt == CNT_DEC);
  assign bit_end_c   = (cnt == CNT_LAST);
  assign last_bit_c  = (bit_idx == IDX_LAST);
  assign stop_last_c = (stop_idx == STOP_LAST);
  assign vote_c      = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (fall_c) state_nx = S_START;
      end
      S_START: begin
        if (decide_c && vote_c) state_nx = S_IDLE;
        else if (bit_end_c)     state_nx = S_DATA;
      end
      S_DATA: begin
        if (bit_end_c && last_bit_c) state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end_c) state_nx = S_STOP;
      end
      S_STOP: begin
        // Leave on the last stop-bit decision so a back-to-back start edge is caught
        if (decide_c && stop_last_c) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr_c   = 1'b0;
    frame_clr_c = 1'b0;
    shift_c     = 1'b0;
    idx_inc_c   = 1'b0;
    par_cap_c   = 1'b0;
    stop_cap_c  = 1'b0;
    stop_inc_c  = 1'b0;
    commit_c    = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_clr_c   = 1'b1;
        frame_clr_c = 1'b1;
      end
      S_START: begin
        cnt_clr_c = bit_end_c;
      end
      S_DATA: begin
        shift_c   = decide_c;
        idx_inc_c = bit_end_c;
        cnt_clr_c = bit_end_c;
      end
      S_PARITY: begin
        par_cap_c = decide_c;
        cnt_clr_c = bit_end_c;
      end
      S_STOP: begin
        stop_cap_c = decide_c;
        commit_c   = decide_c & stop_last_c;
        stop_inc_c = bit_end_c;
        cnt_clr_c  = bit_end_c;
      end
      default: begin
        cnt_clr_c   = 1'b1;
        frame_clr_c = 1'b1;
      end
    endcase
  end

  // Bit timing, majority samples and frame assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      smp       <= 2'b11;
      shreg     <= '0;
      par_bit   <= 1'b0;
      ferr_pend <= 1'b0;
    end else begin
      cnt <= cnt_clr_c ? '0 : cnt + CW'(1);
      if (cnt == CNT_S0) smp[0] <= rx_s;
      if (cnt == CNT_S1) smp[1] <= rx_s;
      if (frame_clr_c) begin
        bit_idx   <= '0;
        stop_idx  <= 1'b0;
        ferr_pend <= 1'b0;
      end else begin
        if (idx_inc_c)              bit_idx   <= bit_idx + BW'(1);
        if (stop_inc_c)             stop_idx  <= 1'b1;
        if (stop_cap_c && !vote_c)  ferr_pend <= 1'b1;
      end
      if (shift_c)   shreg   <= {vote_c, shreg[WIDTH-1:1]};
      if (par_cap_c) par_bit <= vote_c;
    end
  end

  assign frame_err_c  = ferr_pend | ~vote_c;
  assign parity_err_c = (PARITY != 0) ? (par_bit ^ (^shreg) ^ PAR_ODD) : 1'b0;
  assign handshake_c  = bus.valid & bus.ready;

  // Output register: a commit replaces the word only if the slot is free or being drained
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data       <= '0;
      bus.valid      <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else if (commit_c && (!bus.valid || bus.ready)) begin
      bus.data       <= shreg;
      bus.valid      <= 1'b1;
      bus.parity_err <= parity_err_c;
      bus.frame_err  <= frame_err_c;
      if (handshake_c) bus.overrun <= 1'b0;
    end else if (commit_c) begin
      bus.overrun <= 1'b1;
    end else if (handshake_c) begin
      bus.valid   <= 1'b0;
      bus.overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed and randomised checks of uart_rx_framed in 8N1, 8E1 and 8O2 configurations.
module tb_uart_rx_framed;

  localparam int unsigned BITCYC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx_v;
  logic [2:0] rdy;
  int         total = 0;
  int         bad = 0;
  int         lat;
  int         k;
  bit         stable;

  always #5 clk = ~clk;

  uart_rx_framed_if #(.WIDTH(8)) b0 ();
  uart_rx_framed_if #(.WIDTH(8)) b1 ();
  uart_rx_framed_if #(.WIDTH(8)) b2 ();

  assign b0.ready = rdy[0];
  assign b1.ready = rdy[1];
  assign b2.ready = rdy[2];

  uart_rx_framed #(.WIDTH(8), .CLKDIV(16), .PARITY(0), .STOP_BITS(1)) d0 (
    .clk(clk), .rst(rst), .rx(rx_v[0]), .bus(b0));
  uart_rx_framed #(.WIDTH(8), .CLKDIV(16), .PARITY(1), .STOP_BITS(1)) d1 (
    .clk(clk), .rst(rst), .rx(rx_v[1]), .bus(b1));
  uart_rx_framed #(.WIDTH(8), .CLKDIV(16), .PARITY(2), .STOP_BITS(2)) d2 (
    .clk(clk), .rst(rst), .rx(rx_v[2]), .bus(b2));

  logic [2:0] vld, pe, fe, ov;
  logic [7:0] dq [3];

  assign vld   = {b2.valid, b1.valid, b0.valid};
  assign pe    = {b2.parity_err, b1.parity_err, b0.parity_err};
  assign fe    = {b2.frame_err, b1.frame_err, b0.frame_err};
  assign ov    = {b2.overrun, b1.overrun, b0.overrun};
  assign dq[0] = b0.data;
  assign dq[1] = b1.data;
  assign dq[2] = b2.data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int par_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 2);
  endfunction

  function automatic int nstop_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  // Ideal transmitter: start, data LSB first, optional parity, stop bits
  function automatic logic [15:0] mk_frame(input logic [7:0] dat, input int par, input bit pflip,
                                           input int nstop, input bit sbad, output int n);
    logic [15:0] f;
    int          i;
    logic        p;
    f = '1;
    i = 0;
    f[i] = 1'b0;
    i++;
    for (int b = 0; b < 8; b++) begin
      f[i] = dat[b];
      i++;
    end
    if (par != 0) begin
      p = ($countones(dat) % 2) == 1;
      if (par == 2) p = !p;
      f[i] = p ^ pflip;
      i++;
    end
    for (int s = 0; s < nstop; s++) begin
      f[i] = (sbad && s == nstop - 1) ? 1'b0 : 1'b1;
      i++;
    end
    n = i;
    return f;
  endfunction

  task automatic drive_frame(input int d, input logic [15:0] f, input int n, input int gl);
    for (int i = 0; i < n; i++) begin
      rx_v[d] = f[i];
      for (int c = 0; c < BITCYC; c++) begin
        if (i == gl && c == 8) rx_v[d] = ~f[i];
        if (i == gl && c == 9) rx_v[d] = f[i];
        tick();
      end
    end
    rx_v[d] = 1'b1;
  endtask

  task automatic send(input int d, input logic [7:0] dat, input bit pflip, input bit sbad,
                      input int gl);
    logic [15:0] f;
    int          n;
    f = mk_frame(dat, par_of(d), pflip, nstop_of(d), sbad, n);
    drive_frame(d, f, n, gl);
  endtask

  task automatic expect_word(input int d, input string tag, input logic [7:0] dat,
                             input bit epe, input bit efe, input bit eov);
    int c;
    c = 0;
    while (!vld[d] && c < 60) begin
      tick();
      c++;
    end
    chk({tag, "_valid"}, 32'(vld[d]), 32'd1);
    chk({tag, "_data"}, 32'(dq[d]), 32'(dat));
    chk({tag, "_perr"}, 32'(pe[d]), 32'(epe));
    chk({tag, "_ferr"}, 32'(fe[d]), 32'(efe));
    chk({tag, "_ovr"}, 32'(ov[d]), 32'(eov));
  endtask

  task automatic hs(input int d, input string tag);
    rdy[d] = 1'b1;
    tick();
    rdy[d] = 1'b0;
    chk({tag, "_hs_valid"}, 32'(vld[d]), 32'd0);
    chk({tag, "_hs_ovr"}, 32'(ov[d]), 32'd0);
  endtask

  task automatic idle(input int d, input int cycles);
    rx_v[d] = 1'b1;
    repeat (cycles) tick();
  endtask

  initial begin
    logic [7:0] rd;
    int         rdut;
    bit         rpf, rsb;

    rst  = 1'b1;
    rx_v = 3'b111;
    rdy  = 3'b000;
    repeat (3) tick();
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_data0", 32'(dq[0]), 32'd0);
    chk("rst_flags", 32'({pe, fe, ov}), 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_release_valid", 32'(vld), 32'd0);

    // 1: 0xA5 8N1, latency, hold while not ready, then drain
    fork
      send(0, 8'hA5, 1'b0, 1'b0, -1);
      begin
        lat = 0;
        while (!vld[0] && lat < 400) begin
          tick();
          lat++;
        end
      end
    join
    chk("t1_latency_window", 32'(lat >= 155 && lat <= 157), 32'd1);
    expect_word(0, "t1", 8'hA5, 1'b0, 1'b0, 1'b0);
    stable = 1'b1;
    repeat (100) begin
      tick();
      if (!(vld[0] === 1'b1 && dq[0] === 8'hA5)) stable = 1'b0;
    end
    chk("t1_hold", 32'(stable), 32'd1);
    hs(0, "t1");

    // 2: short low pulse is a false start; glitch in bit 3 is voted out
    rx_v[0] = 1'b0;
    repeat (4) tick();
    idle(0, 60);
    chk("t2_false_start", 32'(vld[0]), 32'd0);
    send(0, 8'h3C, 1'b0, 1'b0, 4);
    expect_word(0, "t2", 8'h3C, 1'b0, 1'b0, 1'b0);
    hs(0, "t2");
    idle(0, 8);

    // 3: even parity, wrong then right
    send(1, 8'h3C, 1'b1, 1'b0, -1);
    expect_word(1, "t3_bad", 8'h3C, 1'b1, 1'b0, 1'b0);
    hs(1, "t3_bad");
    idle(1, 8);
    send(1, 8'h3C, 1'b0, 1'b0, -1);
    expect_word(1, "t3_good", 8'h3C, 1'b0, 1'b0, 1'b0);
    hs(1, "t3_good");

    // 4: framing errors, recovery, 2nd stop bit low, held-low break
    send(0, 8'h81, 1'b0, 1'b1, -1);
    expect_word(0, "t4_ferr", 8'h81, 1'b0, 1'b1, 1'b0);
    hs(0, "t4_ferr");
    idle(0, BITCYC);
    send(0, 8'h55, 1'b0, 1'b0, -1);
    expect_word(0, "t4_recover", 8'h55, 1'b0, 1'b0, 1'b0);
    hs(0, "t4_recover");
    idle(0, 8);
    send(2, 8'h5A, 1'b0, 1'b1, -1);
    expect_word(2, "t4_stop2", 8'h5A, 1'b0, 1'b1, 1'b0);
    hs(2, "t4_stop2");
    idle(2, 8);
    send(0, 8'h00, 1'b0, 1'b1, -1);
    rx_v[0] = 1'b0;
    expect_word(0, "t4_break", 8'h00, 1'b0, 1'b1, 1'b0);
    hs(0, "t4_break");
    repeat (300) tick();
    chk("t4_break_quiet", 32'(vld[0]), 32'd0);
    idle(0, BITCYC);

    // 5: overrun on back-to-back words, then replacement on a same-cycle handshake
    send(0, 8'h11, 1'b0, 1'b0, -1);
    send(0, 8'h22, 1'b0, 1'b0, -1);
    expect_word(0, "t5_ovr", 8'h11, 1'b0, 1'b0, 1'b1);
    hs(0, "t5_ovr");
    idle(0, 8);
    fork
      begin
        send(0, 8'h11, 1'b0, 1'b0, -1);
        send(0, 8'h22, 1'b0, 1'b0, -1);
      end
      begin
        k = 0;
        while (!vld[0] && k < 400) begin
          tick();
          k++;
        end
        repeat (BITCYC * 10 - 1) tick();
        rdy[0] = 1'b1;
        tick();
        rdy[0] = 1'b0;
      end
    join
    expect_word(0, "t5_replace", 8'h22, 1'b0, 1'b0, 1'b0);
    hs(0, "t5_replace");
    idle(0, 8);

    // 6: reset in data bit 4 aborts the frame and clears a pending word
    send(1, 8'h3C, 1'b1, 1'b0, -1);
    expect_word(1, "t6_pending", 8'h3C, 1'b1, 1'b0, 1'b0);
    drive_frame(0, 16'h001E, 5, -1);
    rx_v[0] = 1'b0;
    repeat (8) tick();
    rst     = 1'b1;
    rx_v[0] = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(vld), 32'd0);
    chk("t6_rst_data1", 32'(dq[1]), 32'd0);
    chk("t6_rst_flags", 32'({pe, fe, ov}), 32'd0);
    rst = 1'b0;
    repeat (200) tick();
    chk("t6_no_partial", 32'(vld), 32'd0);
    send(0, 8'hF0, 1'b0, 1'b0, -1);
    expect_word(0, "t6_after", 8'hF0, 1'b0, 1'b0, 1'b0);
    hs(0, "t6_after");
    idle(0, 8);

    // Randomised frames against the transmitter model
    for (int it = 0; it < 10; it++) begin
      rdut = int'($urandom_range(0, 2));
      rd   = 8'($urandom);
      rpf  = (rdut != 0) && ($urandom_range(0, 1) == 1);
      rsb  = ($urandom_range(0, 3) == 0);
      send(rdut, rd, rpf, rsb, -1);
      expect_word(rdut, "rand", rd, rpf, rsb, 1'b0);
      hs(rdut, "rand");
      idle(rdut, BITCYC + int'($urandom_range(0, 20)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
